// File: rtl/debounce_bank.sv
// N-channel debouncer: per-channel synchroniser, saturating stability counter,
// debounced level and one-cycle rise/fall pulses.
module debounce_bank #(
  parameter int WIDTH = 4,
  parameter int THRESHOLD = 6000,
  parameter int SYNC_STAGES = 2,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] raw,
  output logic [WIDTH-1:0] level,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall,
  output logic             busy
);

  localparam int CW = (THRESHOLD < 1) ? 1 : $clog2(THRESHOLD + 1);
  localparam logic [CW-1:0] LAST = CW'(THRESHOLD - 1);

  logic [WIDTH-1:0] sq [SYNC_STAGES];
  logic [WIDTH-1:0] sync;
  logic [CW-1:0]    cnt [WIDTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < SYNC_STAGES; s++)
        sq[s] <= RESET_VAL;
    end else begin
      sq[0] <= raw;
      for (int s = 1; s < SYNC_STAGES; s++)
        sq[s] <= sq[s-1];
    end
  end

  assign sync = sq[SYNC_STAGES-1];
  assign busy = |(sync ^ level);

  // en only paces the count; a bounce back to level always clears it
  always_ff @(posedge clk) begin
    if (rst) begin
      level <= RESET_VAL;
      rise  <= '0;
      fall  <= '0;
      for (int i = 0; i < WIDTH; i++)
        cnt[i] <= '0;
    end else begin
      rise <= '0;
      fall <= '0;
      for (int i = 0; i < WIDTH; i++) begin
        if (sync[i] == level[i]) begin
          cnt[i] <= '0;
        end else if (en) begin
          if (cnt[i] == LAST) begin
            level[i] <= sync[i];
            rise[i]  <= sync[i];
            fall[i]  <= ~sync[i];
            cnt[i]   <= '0;
          end else begin
            cnt[i] <= cnt[i] + 1'b1;
          end
        end
      end
    end
  end

endmodule
